// File: rtl/lsu_mem_stage_pkg.sv
// Shared funct3 encodings, FSM state type and the alignment check for the LSU memory stage.
package lsu_mem_stage_pkg;

  localparam logic [2:0] LSU_OP_B  = 3'b000;
  localparam logic [2:0] LSU_OP_H  = 3'b001;
  localparam logic [2:0] LSU_OP_W  = 3'b010;
  localparam logic [2:0] LSU_OP_BU = 3'b100;
  localparam logic [2:0] LSU_OP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_t;

  // Size lives in funct3[1:0]; byte accesses and unused encodings never misalign.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lane);
    case (op[1:0])
      2'b01:   return lane[0];
      2'b10:   return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// Combinational load alignment: selects the addressed byte/half of a read word and extends it.
module lsu_mem_stage_load_align
  import lsu_mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      lane,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] byte_shifted;
  logic [XLEN-1:0] half_shifted;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  assign byte_shifted = rdata >> {lane, 3'b000};
  assign half_shifted = rdata >> {lane[1], 4'b0000};
  assign byte_sel     = byte_shifted[7:0];
  assign half_sel     = half_shifted[15:0];

  always_comb begin
    data = rdata;
    case (op)
      LSU_OP_B:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LSU_OP_BU: data = {{(XLEN-8){1'b0}}, byte_sel};
      LSU_OP_H:  data = {{(XLEN-16){half_sel[15]}}, half_sel};
      LSU_OP_HU: data = {{(XLEN-16){1'b0}}, half_sel};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// LSU memory stage: captures one instr, issues at most one dmem transaction, presents aligned result.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic              ex_mem_ren,
  input  logic              ex_mem_wen,
  input  logic [2:0]        ex_mem_op,
  input  logic [1:0]        ex_reg_wdata_sel,
  input  logic [XLEN-1:0]   ex_csr_rdata,
  input  logic              ex_reg_wen,
  input  logic [REG_AW-1:0] ex_reg_waddr,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [XLEN-1:0]   lsu_alu_result,
  output logic [1:0]        lsu_reg_wdata_sel,
  output logic [XLEN-1:0]   lsu_csr_rdata,
  output logic              lsu_reg_wen,
  output logic [REG_AW-1:0] lsu_reg_waddr,
  output logic [XLEN-1:0]   lsu_dmem_rdata,
  output logic              lsu_misalign,
  output logic              lsu_fault,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [XLEN-1:0]   dmem_req_addr,
  output logic [XLEN-1:0]   dmem_req_wdata,
  output logic [3:0]        dmem_req_wstrb,
  input  logic              dmem_resp_valid,
  output logic              dmem_resp_ready,
  input  logic [XLEN-1:0]   dmem_resp_rdata,
  input  logic              dmem_resp_err
);

  lsu_state_t      state_reg, state_next;
  logic            accept;
  logic            mem_in;
  logic            misalign_in;
  logic            ren_reg;
  logic            wen_reg;
  logic [2:0]      mem_op_reg;
  logic [XLEN-1:0] store_data_reg;
  logic [XLEN-1:0] load_data;

  assign i_ready         = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && o_ready);
  assign accept          = i_valid && i_ready;
  assign mem_in          = ex_mem_ren || ex_mem_wen;
  assign misalign_in     = mem_in && is_misaligned(ex_mem_op, ex_alu_result[1:0]);

  assign o_valid         = (state_reg == ST_DONE);
  assign dmem_req_valid  = (state_reg == ST_REQ);
  assign dmem_resp_ready = (state_reg == ST_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = (mem_in && !misalign_in) ? ST_REQ : ST_DONE;
      end
      ST_REQ: begin
        if (dmem_req_ready) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (dmem_resp_valid) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (accept) begin
          state_next = (mem_in && !misalign_in) ? ST_REQ : ST_DONE;
        end else if (o_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture on accept; the response only updates load data and the fault-related fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      lsu_alu_result    <= '0;
      lsu_reg_wdata_sel <= '0;
      lsu_csr_rdata     <= '0;
      lsu_reg_wen       <= 1'b0;
      lsu_reg_waddr     <= '0;
      lsu_dmem_rdata    <= '0;
      lsu_misalign      <= 1'b0;
      lsu_fault         <= 1'b0;
      ren_reg           <= 1'b0;
      wen_reg           <= 1'b0;
      mem_op_reg        <= '0;
      store_data_reg    <= '0;
    end else if (accept) begin
      lsu_alu_result    <= ex_alu_result;
      lsu_reg_wdata_sel <= ex_reg_wdata_sel;
      lsu_csr_rdata     <= ex_csr_rdata;
      lsu_reg_wen       <= ex_reg_wen && !misalign_in;
      lsu_reg_waddr     <= ex_reg_waddr;
      lsu_dmem_rdata    <= '0;
      lsu_misalign      <= misalign_in;
      lsu_fault         <= 1'b0;
      ren_reg           <= ex_mem_ren;
      wen_reg           <= ex_mem_wen;
      mem_op_reg        <= ex_mem_op;
      store_data_reg    <= ex_store_data;
    end else if ((state_reg == ST_WAIT) && dmem_resp_valid) begin
      if (dmem_resp_err) begin
        lsu_fault      <= 1'b1;
        lsu_reg_wen    <= 1'b0;
        lsu_dmem_rdata <= '0;
      end else if (ren_reg) begin
        lsu_dmem_rdata <= load_data;
      end
    end
  end

  lsu_mem_stage_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .rdata(dmem_resp_rdata),
    .lane (lsu_alu_result[1:0]),
    .op   (mem_op_reg),
    .data (load_data)
  );

  assign dmem_req_we   = wen_reg;
  assign dmem_req_addr = {lsu_alu_result[XLEN-1:2], 2'b00};

  always_comb begin
    dmem_req_wstrb = 4'b0000;
    dmem_req_wdata = store_data_reg;
    if (wen_reg) begin
      case (mem_op_reg[1:0])
        2'b00: begin
          dmem_req_wstrb = 4'b0001 << lsu_alu_result[1:0];
          dmem_req_wdata = {(XLEN/8){store_data_reg[7:0]}};
        end
        2'b01: begin
          dmem_req_wstrb = 4'b0011 << lsu_alu_result[1:0];
          dmem_req_wdata = {(XLEN/16){store_data_reg[15:0]}};
        end
        default: begin
          dmem_req_wstrb = 4'b1111;
          dmem_req_wdata = store_data_reg;
        end
      endcase
    end
  end

endmodule
